// File: rtl/gbe_rx_overflow_counter.sv
// Overrun/bad-frame event counter for a 10GbE receive port: acknowledges each
// overrun episode once and keeps saturating (or wrapping) counts for the PPC.
module gbe_rx_overflow_counter #(
    parameter int C_CNT_WIDTH = 32,
    parameter bit C_SATURATE  = 1'b1
) (
    input  logic                   user_clk,
    input  logic                   user_rst_n,
    input  logic                   rx_overrun,
    input  logic                   rx_valid,
    input  logic                   rx_eof,
    input  logic                   rx_bad_frame,
    input  logic                   ctr_rst,
    input  logic                   ctr_en,
    output logic                   rx_overrun_ack,
    output logic [C_CNT_WIDTH-1:0] of_count,
    output logic [C_CNT_WIDTH-1:0] bad_count,
    output logic                   of_sticky
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} state_t;

    state_t state, state_nxt;
    logic   of_event;
    logic   bad_event;

    localparam logic [C_CNT_WIDTH-1:0] ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [C_CNT_WIDTH-1:0] bump(input logic [C_CNT_WIDTH-1:0] v);
        if (C_SATURATE && (&v))
            return v;
        return v + ONE;
    endfunction

    always_comb begin
        state_nxt = state;
        of_event  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_overrun) begin
                    state_nxt = ACK;
                    of_event  = 1'b1;
                end
            end
            ACK:      state_nxt = WAIT_CLR;
            WAIT_CLR: if (!rx_overrun) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign bad_event = rx_valid & rx_eof & rx_bad_frame & ctr_en;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Ack is registered from the ACK state so it lags the count by one edge.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n)
            rx_overrun_ack <= 1'b0;
        else
            rx_overrun_ack <= (state == ACK);
    end

    // Software clear wins over any coincident event; the FSM is unaffected.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            of_count  <= '0;
            bad_count <= '0;
            of_sticky <= 1'b0;
        end else if (ctr_rst) begin
            of_count  <= '0;
            bad_count <= '0;
            of_sticky <= 1'b0;
        end else begin
            if (of_event && ctr_en)
                of_count <= bump(of_count);
            if (bad_event)
                bad_count <= bump(bad_count);
            if (of_event)
                of_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gbe_rx_overflow_counter.sv
// Bench for gbe_rx_overflow_counter: cycle model feeding an expectation queue,
// a bad-frame vector table, and narrow-width instances for the count limits.
module tb_gbe_rx_overflow_counter;

    logic        user_clk = 1'b0;
    logic        user_rst_n, rx_overrun, rx_valid, rx_eof, rx_bad_frame, ctr_rst, ctr_en;
    logic        rx_overrun_ack, of_sticky;
    logic [31:0] of_count, bad_count;

    // Narrow instances share one stimulus set so the limit can be reached quickly.
    logic        s_rst_n, s_ov, s_v, s_e, s_b;
    logic        ack_s, stk_s, ack_w, stk_w;
    logic [2:0]  of_s, bad_s, of_w, bad_w;

    always #5 user_clk = ~user_clk;

    gbe_rx_overflow_counter #(.C_CNT_WIDTH(32), .C_SATURATE(1'b1)) dut (
        .user_clk(user_clk), .user_rst_n(user_rst_n), .rx_overrun(rx_overrun),
        .rx_valid(rx_valid), .rx_eof(rx_eof), .rx_bad_frame(rx_bad_frame),
        .ctr_rst(ctr_rst), .ctr_en(ctr_en), .rx_overrun_ack(rx_overrun_ack),
        .of_count(of_count), .bad_count(bad_count), .of_sticky(of_sticky));

    gbe_rx_overflow_counter #(.C_CNT_WIDTH(3), .C_SATURATE(1'b1)) dut_sat (
        .user_clk(user_clk), .user_rst_n(s_rst_n), .rx_overrun(s_ov),
        .rx_valid(s_v), .rx_eof(s_e), .rx_bad_frame(s_b),
        .ctr_rst(1'b0), .ctr_en(1'b1), .rx_overrun_ack(ack_s),
        .of_count(of_s), .bad_count(bad_s), .of_sticky(stk_s));

    gbe_rx_overflow_counter #(.C_CNT_WIDTH(3), .C_SATURATE(1'b0)) dut_wrap (
        .user_clk(user_clk), .user_rst_n(s_rst_n), .rx_overrun(s_ov),
        .rx_valid(s_v), .rx_eof(s_e), .rx_bad_frame(s_b),
        .ctr_rst(1'b0), .ctr_en(1'b1), .rx_overrun_ack(ack_w),
        .of_count(of_w), .bad_count(bad_w), .of_sticky(stk_w));

    typedef struct {
        logic        ack;
        logic [31:0] ofc;
        logic [31:0] bdc;
        logic        stk;
    } exp_t;

    typedef struct {
        logic        v;
        logic        e;
        logic        b;
        logic        en;
        logic [31:0] exp_bad;
    } vec_t;

    exp_t        q[$];
    vec_t        tbl[14];
    int          n_total = 0;
    int          n_bad   = 0;
    int          n_ack   = 0;

    int          m_st;
    logic        m_ack, m_stk;
    logic [31:0] m_of, m_bad;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_ack = 1'b0; m_of = '0; m_bad = '0; m_stk = 1'b0;
    endtask

    // Drive one cycle, predict post-edge outputs, compare one time unit after the edge.
    task automatic cyc(input logic rn, input logic ov, input logic v, input logic e,
                       input logic b, input logic cr, input logic en);
        exp_t x;
        logic ev;
        user_rst_n = rn; rx_overrun = ov; rx_valid = v; rx_eof = e;
        rx_bad_frame = b; ctr_rst = cr; ctr_en = en;
        if (!rn) begin
            model_reset();
        end else begin
            ev    = (m_st == 0) && ov;
            m_ack = (m_st == 1);
            case (m_st)
                0:       m_st = ov ? 1 : 0;
                1:       m_st = 2;
                default: m_st = ov ? 2 : 0;
            endcase
            if (cr) begin
                m_of = '0; m_bad = '0; m_stk = 1'b0;
            end else begin
                if (ev && en && m_of != 32'hFFFF_FFFF) m_of = m_of + 1;
                if (v && e && b && en && m_bad != 32'hFFFF_FFFF) m_bad = m_bad + 1;
                if (ev) m_stk = 1'b1;
            end
        end
        x = '{m_ack, m_of, m_bad, m_stk};
        q.push_back(x);
        @(posedge user_clk);
        #1;
        x = q.pop_front();
        chk("ack", 32'(rx_overrun_ack), 32'(x.ack));
        chk("of_count", of_count, x.ofc);
        chk("bad_count", bad_count, x.bdc);
        chk("of_sticky", 32'(of_sticky), 32'(x.stk));
        if (rx_overrun_ack) n_ack++;
    endtask

    task automatic idle(input int n, input logic en);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, en);
    endtask

    task automatic small_episode();
        s_ov = 1; s_v = 1; s_e = 1; s_b = 1;
        @(posedge user_clk); #1;
        s_ov = 0; s_v = 0; s_e = 0; s_b = 0;
        repeat (2) @(posedge user_clk);
        #1;
    endtask

    initial begin
        // v, e, b, en, expected bad_count after the edge
        tbl[0]  = '{1, 1, 0, 1, 0};
        tbl[1]  = '{1, 1, 1, 1, 1};
        tbl[2]  = '{1, 0, 1, 1, 1};
        tbl[3]  = '{0, 1, 1, 1, 1};
        tbl[4]  = '{1, 1, 1, 1, 2};
        tbl[5]  = '{1, 1, 0, 1, 2};
        tbl[6]  = '{1, 1, 1, 1, 3};
        tbl[7]  = '{1, 1, 0, 1, 3};
        tbl[8]  = '{1, 1, 0, 1, 3};
        tbl[9]  = '{1, 1, 1, 1, 4};
        tbl[10] = '{1, 1, 0, 1, 4};
        tbl[11] = '{1, 1, 0, 1, 4};
        tbl[12] = '{1, 1, 1, 0, 4};
        tbl[13] = '{1, 1, 0, 1, 4};

        user_rst_n = 0; rx_overrun = 0; rx_valid = 0; rx_eof = 0;
        rx_bad_frame = 0; ctr_rst = 0; ctr_en = 1;
        s_rst_n = 0; s_ov = 0; s_v = 0; s_e = 0; s_b = 0;
        model_reset();
        #1;

        // Reset held, overrun asserted: outputs stay at reset values.
        cyc(0, 0, 0, 0, 0, 0, 1);
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 1);
        n_ack = 0;
        cyc(1, 1, 0, 0, 0, 0, 1);
        chk("release_of_count", of_count, 32'd1);
        repeat (2) cyc(1, 1, 0, 0, 0, 0, 1);
        idle(3, 1);
        chk("release_ack_pulses", n_ack, 1);

        // Long episode, 1-cycle gap, short episode.
        cyc(1, 0, 0, 0, 0, 1, 1);
        n_ack = 0;
        repeat (50) cyc(1, 1, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 0, 0, 1);
        idle(3, 1);
        chk("long_of_count", of_count, 32'd2);
        chk("long_ack_pulses", n_ack, 2);
        chk("long_sticky", 32'(of_sticky), 32'd1);

        // Bad-frame vectors from a cleared start.
        cyc(1, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 14; i++) begin
            cyc(1, 0, tbl[i].v, tbl[i].e, tbl[i].b, 0, tbl[i].en);
            chk($sformatf("vec%0d_bad_count", i), bad_count, tbl[i].exp_bad);
        end

        // Clear coincident with an overrun event and a bad eof.
        cyc(1, 1, 1, 1, 1, 0, 1);
        idle(2, 1);
        chk("pre_clear_sticky", 32'(of_sticky), 32'd1);
        n_ack = 0;
        cyc(1, 1, 1, 1, 1, 1, 1);
        idle(3, 1);
        chk("clear_of_count", of_count, 32'd0);
        chk("clear_bad_count", bad_count, 32'd0);
        chk("clear_sticky", 32'(of_sticky), 32'd0);
        chk("clear_ack_pulses", n_ack, 1);

        // Counting disabled: FSM, ack and sticky still work.
        n_ack = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 0);
            idle(2, 0);
        end
        chk("en0_of_count", of_count, 32'd0);
        chk("en0_ack_pulses", n_ack, 3);
        chk("en0_sticky", 32'(of_sticky), 32'd1);

        // Reset asserted mid-episode while ack is high.
        repeat (2) cyc(1, 1, 0, 0, 0, 0, 1);
        #2 user_rst_n = 0;
        #1;
        model_reset();
        chk("async_ack", 32'(rx_overrun_ack), 32'd0);
        chk("async_of_count", of_count, 32'd0);
        chk("async_sticky", 32'(of_sticky), 32'd0);
        @(posedge user_clk); #1;
        cyc(1, 1, 0, 0, 0, 0, 1);
        chk("post_reset_of_count", of_count, 32'd1);
        idle(3, 1);

        // Narrow counters: preload to all-ones minus one, then 3 more events.
        s_rst_n = 1;
        for (int i = 0; i < 6; i++) small_episode();
        chk("sat_preload_of", 32'(of_s), 32'd6);
        chk("wrap_preload_bad", 32'(bad_w), 32'd6);
        for (int i = 0; i < 3; i++) small_episode();
        chk("sat_of_count", 32'(of_s), 32'd7);
        chk("sat_bad_count", 32'(bad_s), 32'd7);
        chk("wrap_of_count", 32'(of_w), 32'd1);
        chk("wrap_bad_count", 32'(bad_w), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
